fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side drain stage placed directly downstream of the team's synchronous FIFO. It issues `fifo_rd_en` only when the FIFO is non-empty and buffer space is guaranteed. It captures the FIFO's registered read data after a fixed latency and presents it as a valid/ready stream. An internal skid buffer sustains one word per cycle under back-pressure without ever reading an empty FIFO or dropping a word.

## Interface
- `DATA_W`, default 4: word width; must match the FIFO data width.
- `RD_LAT`, default 1: cycles from `fifo_rd_en` high at a clock edge to the word being valid on `fifo_data`. Legal values are 1 and 2.
- `BUF_D`, derived as `RD_LAT+1`: skid buffer depth in words.

Ports:
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `rst_a`  in  1  — asynchronous, active-low reset (asserted at 0).
- `flush`  in  1  — synchronous; discards buffered and in-flight words.
- `fifo_empty`  in  1  — FIFO empty flag.
- `fifo_data`  in  `DATA_W`  — FIFO read data.
- `fifo_rd_en`  out  1  — FIFO read strobe.
- `m_valid`  out  1  — stream word valid.
- `m_data`  out  `DATA_W`  — stream word.
- `m_ready`  in  1  — downstream accepts the word.
- `idle`  out  1  — no buffered and no in-flight words.

## Operation
- State:
  - `BUF_D`-entry circular buffer with read/write indices.
  - Occupancy counter `occ` (0..`BUF_D`).
  - `RD_LAT`-deep shift register `pend` marking in-flight reads.
  - `infl` = population count of `pend`.
- Pop: `pop = m_valid & m_ready`.
- Read issue (combinational): `fifo_rd_en = !fifo_empty & !flush & (occ + infl - pop) < BUF_D`.
  - `fifo_rd_en` is never high while `fifo_empty` is high.
  - Sum width is `clog2(BUF_D+RD_LAT+1)` bits; no wrap.
- Capture: when the last stage of `pend` is 1, `fifo_data` is written to the buffer tail and `occ` increments.
- Output: `m_valid = (occ != 0)`; `m_data` = buffer head. Head entries are registered and stable while `m_valid & !m_ready`.
- Simultaneous capture and pop: `occ` is unchanged, both indices advance, and the data order is preserved.
- Index wrap-around: indices wrap modulo `BUF_D`. Capture order into the buffer equals FIFO read order, which equals stream order.
- Flush:
  - At the edge where `flush`=1: `occ`←0, indices←0, `pend`←0.
  - Any word returning from a read issued before the flush is discarded. This holds because `pend` is cleared, and no read is issued during flush.
  - `m_valid` is 0 from the next cycle.
- `idle = (occ == 0) & (infl == 0)`.
- Overflow is impossible by construction. A capture arriving with `occ == BUF_D` is a design error; verification flags it with an assertion.

## Timing
- Reset (`rst_a`=0, asynchronous):
  - `occ`=0, `pend`=0, indices=0, buffer contents=0.
  - `m_valid`=0, `m_data`=0, `idle`=1.
  - `fifo_rd_en`=0 whenever `fifo_empty`=1; with the FIFO also in reset, it is 0.
- Reset deassertion: the first read can issue in the first cycle after release if `fifo_empty`=0.
- Latency: `fifo_rd_en` high at edge t → captured at edge t+`RD_LAT` → `m_valid` high in the cycle after edge t+`RD_LAT`.
  - FIFO-to-stream latency is `RD_LAT`+1 cycles for an empty pipeline.
- Throughput: one word per cycle sustained when `m_ready`=1 and the FIFO stays non-empty.
- Back-pressure: with `m_ready`=0, at most `BUF_D` reads are outstanding (buffered plus in flight); then `fifo_rd_en`=0 until a pop.
- Combinational path: `m_ready` to `fifo_rd_en` is combinational. All other outputs are registered or derived only from registers.
- Reset mid-operation: buffered and in-flight words are lost; outputs return to the reset values immediately.

## Test plan
- Reset check:
  - Stimulus: hold `rst_a`=0 with `fifo_empty`=0.
  - Required: `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `idle`=1.
- Streaming, `RD_LAT`=1:
  - Stimulus: preload FIFO with 0x1..0x8, `m_ready`=1.
  - Required: `fifo_rd_en` high 8 consecutive cycles; `m_data` = 0x1..0x8 on 8 consecutive cycles starting 2 cycles after the first read; `idle`=1 afterwards.
- Back-pressure:
  - Stimulus: 6 words in FIFO, `m_ready`=0 for 10 cycles, then 1.
  - Required: exactly `BUF_D` reads issued during the stall; `m_data` held at word 0x1; all 6 words delivered in order with no duplicates.
- Empty boundary:
  - Stimulus: FIFO holds 1 word, `m_ready`=1.
  - Required: exactly one `fifo_rd_en` pulse; never high while `fifo_empty`=1; one stream beat.
- Flush with a read in flight:
  - Stimulus: `RD_LAT`=2, assert `flush` one cycle after a read issues.
  - Required: the returning word is dropped, `m_valid`=0 next cycle, `idle`=1 within 2 cycles.
- Random back-pressure:
  - Stimulus: 200 words, random `m_ready` (50%), both `RD_LAT` values.
  - Required: output sequence equals input sequence; buffer-overflow assertion never fires.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side drain stage for the synchronous FIFO.
// Issues fifo_rd_en only when a buffer slot is guaranteed for the returning
// word. Captures fifo_data RD_LAT cycles later into a small skid buffer and
// presents the buffer head as a valid/ready stream.
// Buffer depth is RD_LAT+1, so one word per cycle can be sustained while
// reads are still in flight.
module fifo_rd_stream #(
    parameter int DATA_W = 4,
    parameter int RD_LAT = 1     // legal values: 1 or 2
) (
    input  logic              clk,
    input  logic              rst_a,       // asynchronous, active low
    input  logic              flush,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              idle
);

    // Skid buffer depth: one slot per in-flight read plus one for the head.
    localparam int BUF_D = RD_LAT + 1;
    localparam int IDX_W = (BUF_D > 1) ? $clog2(BUF_D) : 1;
    localparam int OCC_W = $clog2(BUF_D + 1);
    localparam int INF_W = $clog2(RD_LAT + 1);
    // Wide enough for occ + infl without wrap.
    localparam int SUM_W = $clog2(BUF_D + RD_LAT + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_buf [BUF_D];
    logic [IDX_W-1:0]  r_wr_idx;
    logic [IDX_W-1:0]  r_rd_idx;
    logic [OCC_W-1:0]  r_occ;
    logic [RD_LAT-1:0] r_pend;      // bit k set: a read issued k+1 edges ago

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic              w_valid;
    logic              w_pop;
    logic              w_capture;
    logic [INF_W-1:0]  w_infl;
    logic [SUM_W-1:0]  w_sum;
    logic              w_rd_en;
    logic [BUF_D-1:0]  w_buf_we;
    logic [IDX_W-1:0]  w_wr_idx_inc;
    logic [IDX_W-1:0]  w_rd_idx_inc;

    // Circular index increment, wrapping modulo BUF_D.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] res;
        if (v == IDX_W'(BUF_D - 1)) begin
            res = '0;
        end else begin
            res = v + IDX_W'(1);
        end
        return res;
    endfunction

    assign w_valid      = (r_occ != '0);
    assign w_pop        = w_valid & m_ready;
    assign w_capture    = r_pend[RD_LAT-1];
    assign w_wr_idx_inc = idx_inc(r_wr_idx);
    assign w_rd_idx_inc = idx_inc(r_rd_idx);

    // Population count of the in-flight read markers.
    always_comb begin
        w_infl = '0;
        for (int k = 0; k < RD_LAT; k++) begin
            w_infl = w_infl + INF_W'(r_pend[k]);
        end
    end

    // Slots committed after this edge if the head leaves now; a read may
    // issue only when that leaves room for one more word. Gated by rst_a so
    // that no read issues while the block is held in reset.
    always_comb begin
        w_sum   = SUM_W'(r_occ) + SUM_W'(w_infl) - SUM_W'(w_pop);
        w_rd_en = rst_a & ~fifo_empty & ~flush & (w_sum < SUM_W'(BUF_D));
    end

    // Per-entry write enables: the capture lands at the tail slot only.
    genvar gi;
    generate
        for (gi = 0; gi < BUF_D; gi++) begin : g_we
            assign w_buf_we[gi] = w_capture & ~flush & (r_wr_idx == IDX_W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Skid buffer storage: written at the tail on capture, cleared on reset.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            for (int k = 0; k < BUF_D; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            for (int k = 0; k < BUF_D; k++) begin
                if (w_buf_we[k]) begin
                    r_buf[k] <= fifo_data;
                end
            end
        end
    end

    // Indices and occupancy; flush discards all buffered words.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_occ    <= '0;
        end else if (flush) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_occ    <= '0;
        end else begin
            if (w_capture) begin
                r_wr_idx <= w_wr_idx_inc;
            end
            if (w_pop) begin
                r_rd_idx <= w_rd_idx_inc;
            end
            // Capture and pop together leave occupancy unchanged.
            case ({w_capture, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // In-flight read tracker; clearing it on flush drops returning words.
    generate
        if (RD_LAT == 1) begin : g_pend1
            always_ff @(posedge clk or negedge rst_a) begin
                if (!rst_a) begin
                    r_pend <= '0;
                end else if (flush) begin
                    r_pend <= '0;
                end else begin
                    r_pend <= w_rd_en;
                end
            end
        end else begin : g_pendn
            always_ff @(posedge clk or negedge rst_a) begin
                if (!rst_a) begin
                    r_pend <= '0;
                end else if (flush) begin
                    r_pend <= '0;
                end else begin
                    r_pend <= {r_pend[RD_LAT-2:0], w_rd_en};
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fifo_rd_en = w_rd_en;
    assign m_valid    = w_valid;
    assign m_data     = r_buf[r_rd_idx];
    assign idle       = (r_occ == '0) & (w_infl == '0);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: two instances (RD_LAT=1 and RD_LAT=2) share
// stimulus. Each has a behavioural FIFO with matching read latency. The
// stimulus process records every word it expects on the stream. A monitor
// process pops and compares those words, and also compares the directed
// checks the stimulus posts.
module tb_fifo_rd_stream;

    localparam int DW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a;
    logic          flush;
    logic          m_ready;
    logic [1:0]    fifo_empty;
    logic [1:0]    fifo_rd_en;
    logic [1:0]    m_valid;
    logic [1:0]    idle;
    logic [DW-1:0] fifo_data [2];
    logic [DW-1:0] m_data    [2];

    fifo_rd_stream #(.DATA_W(DW), .RD_LAT(1)) u_dut0 (
        .clk(clk), .rst_a(rst_a), .flush(flush),
        .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]),
        .fifo_rd_en(fifo_rd_en[0]), .m_valid(m_valid[0]),
        .m_data(m_data[0]), .m_ready(m_ready), .idle(idle[0])
    );

    fifo_rd_stream #(.DATA_W(DW), .RD_LAT(2)) u_dut1 (
        .clk(clk), .rst_a(rst_a), .flush(flush),
        .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]),
        .fifo_rd_en(fifo_rd_en[1]), .m_valid(m_valid[1]),
        .m_data(m_data[1]), .m_ready(m_ready), .idle(idle[1])
    );

    // Behavioural FIFOs: stimulus writes fmem/fwp, the model advances frp.
    logic [DW-1:0] fmem [2][512];
    int            fwp  [2];
    int            frp  [2];
    logic [DW-1:0] s1   [2];
    logic [DW-1:0] s2   [2];

    assign fifo_empty[0] = (frp[0] == fwp[0]);
    assign fifo_empty[1] = (frp[1] == fwp[1]);
    assign fifo_data[0]  = s1[0];   // one-cycle read latency
    assign fifo_data[1]  = s2[1];   // two-cycle read latency

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (fifo_rd_en[i]) begin
                frp[i] <= frp[i] + 1;
                s1[i]  <= fmem[i][frp[i] & 511];
            end
            s2[i] <= s1[i];
        end
    end

    // Expected stream words (written by stimulus) and posted directed checks.
    logic [DW-1:0] emem [2][512];
    int            ewp  [2];
    int            erp  [2];
    string         dq_name [512];
    int            dq_act  [512];
    int            dq_exp  [512];
    int            dq_wp;
    int            dq_rp;

    // Overflow probe: a capture while the buffer is already full.
    logic [1:0] cap;
    logic [1:0] occ_full;
    assign cap[0]      = u_dut0.w_capture;
    assign cap[1]      = u_dut1.w_capture;
    assign occ_full[0] = (int'(u_dut0.r_occ) == 2);
    assign occ_full[1] = (int'(u_dut1.r_occ) == 3);

    int checks;
    int errors;

    // Monitor: compares stream beats, protocol rules and posted checks.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_a) begin
                if (fifo_empty[i]) begin
                    checks++;
                    if (fifo_rd_en[i]) begin
                        errors++;
                        $display("FAIL rd_en_while_empty dut%0d: fifo_rd_en=1 required 0", i);
                    end
                end
                if (cap[i]) begin
                    checks++;
                    if (occ_full[i]) begin
                        errors++;
                        $display("FAIL overflow dut%0d: capture with full buffer", i);
                    end
                end
                if (m_valid[i] && m_ready) begin
                    checks++;
                    if (erp[i] >= ewp[i]) begin
                        errors++;
                        $display("FAIL beat dut%0d: unexpected word 0x%0h, none required", i, m_data[i]);
                    end else begin
                        if (m_data[i] !== emem[i][erp[i] & 511]) begin
                            errors++;
                            $display("FAIL beat dut%0d #%0d: got 0x%0h required 0x%0h",
                                     i, erp[i], m_data[i], emem[i][erp[i] & 511]);
                        end else begin
                            $display("beat dut%0d #%0d: 0x%0h", i, erp[i], m_data[i]);
                        end
                        erp[i]++;
                    end
                end
            end
        end
        while (dq_rp < dq_wp) begin
            checks++;
            if (dq_act[dq_rp] != dq_exp[dq_rp]) begin
                errors++;
                $display("FAIL %s: got %0d required %0d", dq_name[dq_rp], dq_act[dq_rp], dq_exp[dq_rp]);
            end else begin
                $display("check %s: %0d", dq_name[dq_rp], dq_act[dq_rp]);
            end
            dq_rp++;
        end
    end

    task automatic dchk(input string nm, input int act, input int exp_v);
        dq_name[dq_wp] = nm;
        dq_act[dq_wp]  = act;
        dq_exp[dq_wp]  = exp_v;
        dq_wp++;
    endtask

    // Put a word into both FIFOs; optionally expect it on both streams.
    task automatic push(input logic [DW-1:0] w, input bit exp_out);
        for (int i = 0; i < 2; i++) begin
            fmem[i][fwp[i] & 511] = w;
            fwp[i] = fwp[i] + 1;
            if (exp_out) begin
                emem[i][ewp[i] & 511] = w;
                ewp[i] = ewp[i] + 1;
            end
        end
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!(idle == 2'b11 && fifo_empty == 2'b11) && n < budget) begin
            @(negedge clk);
            n++;
        end
        dchk(nm, int'(idle == 2'b11 && fifo_empty == 2'b11), 1);
    endtask

    logic [1:0]    rr [16];
    logic [1:0]    vv [16];
    logic [DW-1:0] dd [2][16];
    int            cnt [2];
    int            beats [2];

    initial begin
        rst_a   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        dq_wp   = 0;
        for (int i = 0; i < 2; i++) begin
            fwp[i] = 0;
            ewp[i] = 0;
        end

        // Reset with a non-empty FIFO: nothing may be read or presented.
        push(4'hA, 1'b1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            dchk($sformatf("reset_rd_en dut%0d", i), int'(fifo_rd_en[i]), 0);
            dchk($sformatf("reset_m_valid dut%0d", i), int'(m_valid[i]), 0);
            dchk($sformatf("reset_m_data dut%0d", i), int'(m_data[i]), 0);
            dchk($sformatf("reset_idle dut%0d", i), int'(idle[i]), 1);
        end
        @(posedge clk); #1;
        rst_a = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            dchk($sformatf("release_rd_en dut%0d", i), int'(fifo_rd_en[i]), 1);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_idle("reset_word_drain", 50);

        // Streaming 0x1..0x8 with m_ready held high.
        @(posedge clk); #1;
        for (int w = 1; w <= 8; w++) push(DW'(w), 1'b1);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            rr[c] = fifo_rd_en;
            vv[c] = m_valid;
            dd[0][c] = m_data[0];
            dd[1][c] = m_data[1];
        end
        for (int i = 0; i < 2; i++) begin
            int lat;
            int nrd;
            int first;
            lat = i + 1;
            nrd = 0;
            first = -1;
            for (int c = 0; c < 16; c++) begin
                nrd += int'(rr[c][i]);
                if (first < 0 && vv[c][i]) first = c;
            end
            dchk($sformatf("stream_reads dut%0d", i), nrd, 8);
            dchk($sformatf("stream_rd_first dut%0d", i), int'(rr[0][i]), 1);
            dchk($sformatf("stream_rd_last dut%0d", i), int'(rr[7][i]), 1);
            dchk($sformatf("stream_rd_stop dut%0d", i), int'(rr[8][i]), 0);
            dchk($sformatf("stream_first_valid dut%0d", i), first, lat + 1);
            for (int k = 0; k < 8; k++) begin
                dchk($sformatf("stream_word%0d dut%0d", k, i),
                     vv[lat+1+k][i] ? int'(dd[i][lat+1+k]) : -1, k + 1);
            end
            dchk($sformatf("stream_valid_end dut%0d", i), int'(vv[lat+9][i]), 0);
            dchk($sformatf("stream_idle dut%0d", i), int'(idle[i]), 1);
        end

        // Back-pressure: 6 words, stalled for 10 cycles.
        @(posedge clk); #1;
        m_ready = 1'b0;
        for (int w = 1; w <= 6; w++) push(DW'(w), 1'b1);
        cnt[0] = 0;
        cnt[1] = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) cnt[i] += int'(fifo_rd_en[i]);
        end
        for (int i = 0; i < 2; i++) begin
            dchk($sformatf("stall_reads dut%0d", i), cnt[i], i + 2);
            dchk($sformatf("stall_valid dut%0d", i), int'(m_valid[i]), 1);
            dchk($sformatf("stall_head dut%0d", i), int'(m_data[i]), 1);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_idle("bp_drain", 60);
        for (int i = 0; i < 2; i++) begin
            dchk($sformatf("bp_all_delivered dut%0d", i), erp[i], ewp[i]);
        end

        // Empty boundary: a single word.
        @(posedge clk); #1;
        push(4'h9, 1'b1);
        cnt[0] = 0; cnt[1] = 0; beats[0] = 0; beats[1] = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                cnt[i]   += int'(fifo_rd_en[i]);
                beats[i] += int'(m_valid[i] & m_ready);
            end
        end
        for (int i = 0; i < 2; i++) begin
            dchk($sformatf("single_reads dut%0d", i), cnt[i], 1);
            dchk($sformatf("single_beats dut%0d", i), beats[i], 1);
        end
        wait_idle("single_drain", 20);

        // Flush one cycle after a read issues: the word must be dropped.
        @(posedge clk); #1;
        push(4'hC, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            dchk($sformatf("flush_read_issued dut%0d", i), int'(fifo_rd_en[i]), 1);
        end
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            dchk($sformatf("flush_valid_next dut%0d", i), int'(m_valid[i]), 0);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            dchk($sformatf("flush_valid_late dut%0d", i), int'(m_valid[i]), 0);
            dchk($sformatf("flush_idle dut%0d", i), int'(idle[i]), 1);
        end
        @(posedge clk); #1;
        push(4'hD, 1'b1);
        wait_idle("flush_recover", 20);

        // Random back-pressure over 200 words.
        @(posedge clk); #1;
        for (int w = 0; w < 200; w++) push(DW'($urandom_range(0, 15)), 1'b1);
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            m_ready = ($urandom_range(0, 1) == 1);
            if (idle == 2'b11 && fifo_empty == 2'b11) break;
        end
        m_ready = 1'b1;
        wait_idle("rand_drain", 100);
        for (int i = 0; i < 2; i++) begin
            dchk($sformatf("rand_all_delivered dut%0d", i), erp[i], ewp[i]);
        end

        repeat (3) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
